seq_addsub_accum: RTL and testbench
===================================

// Module: seq_addsub_accum
// PURPOSE
//  Multi-cycle parametrised add/subtract accumulator: computes Out = B + N*A (mode 0)
//  or Out = B - N*A (mode 1), one ripple add/sub of A per clock, with start/done handshake.
//  Generalises the fixed 16-bit adder-subtractor and b_minus_2a datapaths to any WIDTH
//  and any repeat count N (b_minus_2a == mode 1, N = 2). Sits between operand registers
//  and the result/flag display logic of the lab datapath.
// PARAMETERS
//  WIDTH  16  operand / accumulator width in bits
//  CNT_W  4   width of repeat count N (max N = 2**CNT_W - 1)
// PORTS
//  clk    in   1      single system clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  mode   in   1      0 = add A each step, 1 = subtract A each step
//  A      in   WIDTH  step operand
//  B      in   WIDTH  initial accumulator value
//  N      in   CNT_W  number of add/sub steps
//  Out    out  WIDTH  accumulator; final result valid while done = 1, held until next start
//  Cout   out  1      carry of the most recent step (sub: 1 = no borrow)
//  V      out  1      sticky two's-complement overflow over the whole operation
//  busy   out  1      high in RUN and DONE
//  done   out  1      one-cycle pulse, result valid
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; Out, Cout, V, busy, done = 0; cnt = 0.
//    Mid-operation reset aborts; no partial result retained.
//  - States IDLE, RUN, DONE.
//  - IDLE: on start = 1 at edge E0: latch A, mode into regs; Out <= B; cnt <= N;
//    Cout <= 0; V <= 0. Next state RUN if N != 0, else DONE. start = 0 -> stay.
//  - RUN, each edge: Out <= Out + A_r (mode 0) or Out + ~A_r + 1 (mode 1), WIDTH-bit
//    wrap-around; Cout <= carry out of MSB; V <= V | (signed overflow of this step);
//    cnt <= cnt - 1; if cnt == 1 next state DONE.
//  - DONE: done = 1 for exactly one cycle; next state IDLE unconditionally.
//  - Latency: done high in the cycle after edge E0 + N (N = 0 -> cycle after E0).
//  - start while busy = 1 (RUN or DONE) is ignored; A/B/N/mode changes after E0
//    have no effect on the running operation.
//  - Overflow step: mode 0: A_r,Out same sign, sum differs; mode 1: signs differ,
//    result sign differs from Out.
//  - Outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1. mode=1 A=5 B=20 N=2 start -> done 2 edges after E0; Out=0x000A Cout=1 V=0.
//  2. mode=0 A=0x7FFF B=0x0001 N=1 -> Out=0x8000 Cout=0 V=1.
//  3. mode=1 A=3 B=2 N=1 -> Out=0xFFFF Cout=0 (borrow) V=0.
//  4. N=0 B=0x1234 -> done in cycle after E0, Out=0x1234 Cout=0 V=0; mode 0 A=0xFFFF
//     B=0 N=15 -> Out=0xFFF1 (wrap, 15 steps) Cout=1 V=0.
//  5. start re-pulsed during RUN with A=1 B=0 N=1 -> ignored; first result unchanged;
//     exactly one done pulse.
//  6. rst mid-RUN -> Out/Cout/V/busy/done = 0 immediately; next start completes normally.

Source files
------------

// File: rtl/seq_addsub_accum.sv
// Multi-cycle add/subtract accumulator: Out = B + N*A (mode 0) or B - N*A (mode 1),
// one WIDTH-bit ripple add/sub per clock, with start/busy/done handshake and sticky overflow.
module seq_addsub_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [CNT_W-1:0] N,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] out_q, out_d;
  logic signed [WIDTH-1:0] a_q, a_d;
  logic                    mode_q, mode_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    cout_q, cout_d;
  logic                    v_q, v_d;

  // One add/sub step. Returns {overflow, carry_out, sum}.
  // Subtraction is acc + ~opnd + 1, so carry_out = 1 means no borrow.
  function automatic logic [WIDTH+1:0] addsub_step(
    input logic signed [WIDTH-1:0] acc,
    input logic signed [WIDTH-1:0] opnd,
    input logic                    sub
  );
    logic [WIDTH-1:0] opnd_eff;
    logic [WIDTH:0]   full;
    logic             ovf;
    opnd_eff = sub ? ~opnd : opnd;
    full     = {1'b0, acc} + {1'b0, opnd_eff} + {{WIDTH{1'b0}}, sub};
    if (sub) begin
      ovf = (opnd[WIDTH-1] != acc[WIDTH-1]) && (full[WIDTH-1] != acc[WIDTH-1]);
    end else begin
      ovf = (opnd[WIDTH-1] == acc[WIDTH-1]) && (full[WIDTH-1] != acc[WIDTH-1]);
    end
    return {ovf, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  logic [WIDTH+1:0]        step_res;
  logic signed [WIDTH-1:0] step_sum;
  logic                    step_cout;
  logic                    step_ovf;

  always_comb begin
    step_res  = addsub_step(out_q, a_q, mode_q);
    step_sum  = step_res[WIDTH-1:0];
    step_cout = step_res[WIDTH];
    step_ovf  = step_res[WIDTH+1];
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    a_d     = a_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          mode_d  = mode;
          out_d   = B;
          cnt_d   = N;
          cout_d  = 1'b0;
          v_d     = 1'b0;
          state_d = (N != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        out_d  = step_sum;
        cout_d = step_cout;
        v_d    = v_q | step_ovf;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset clears the result too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      a_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  assign Out  = out_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_addsub_accum.sv
// Directed bench for seq_addsub_accum: an independent integer model fills a scoreboard
// queue at each start; entries are popped and compared when done is observed.
module tb_seq_addsub_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  N;
  logic [15:0] Out;
  logic        Cout;
  logic        V;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] out;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];

  seq_addsub_accum #(.WIDTH(16), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (mode),
    .A    (A),
    .B    (B),
    .N    (N),
    .Out  (Out),
    .Cout (Cout),
    .V    (V),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Integer model: unsigned value for wrap/carry, signed range check for overflow.
  task automatic model(input bit m, input logic [15:0] a, input logic [15:0] b, input int n,
                       output logic [15:0] o, output logic c, output logic v);
    int acc;
    int ai;
    int s;
    logic signed [15:0] t;
    int sacc;
    int sa;
    acc = int'(b);
    ai  = int'(a);
    c   = 1'b0;
    v   = 1'b0;
    for (int i = 0; i < n; i++) begin
      t    = acc[15:0];
      sacc = int'(t);
      t    = a;
      sa   = int'(t);
      if (!m) begin
        c   = ((acc + ai) > 65535);
        s   = sacc + sa;
        acc = (acc + ai) & 32'hFFFF;
      end else begin
        c   = (acc >= ai);
        s   = sacc - sa;
        acc = (acc - ai) & 32'hFFFF;
      end
      if (s > 32767 || s < -32768) v = 1'b1;
    end
    o = acc[15:0];
  endtask

  task automatic run_op(input bit m, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] n, input bit repulse, input string tag);
    exp_t e;
    exp_t got;
    int   k;
    @(negedge clk);
    mode  = m;
    A     = a;
    B     = b;
    N     = n;
    start = 1'b1;
    model(m, a, b, int'(n), e.out, e.c, e.v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    N     = 4'($urandom);
    mode  = 1'($urandom);
    k     = 0;
    while (done !== 1'b1 && k < 40) begin
      if (repulse && k == 0) begin
        start = 1'b1;
        A     = 16'h0001;
        B     = 16'h0000;
        N     = 4'd1;
        mode  = 1'b0;
      end
      if (repulse && k == 2) start = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(k), 32'(n));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check({tag, " Out"}, 32'(Out), 32'(got.out));
      check({tag, " Cout"}, 32'(Cout), 32'(got.c));
      check({tag, " V"}, 32'(V), 32'(got.v));
      check({tag, " busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
      check({tag, " Out held"}, 32'(Out), 32'(got.out));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    A     = '0;
    B     = '0;
    N     = '0;
    #12;
    check("reset Out", 32'(Out), 32'd0);
    check("reset Cout", 32'(Cout), 32'd0);
    check("reset V", 32'(V), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // b - 2a
    run_op(1'b1, 16'd5, 16'd20, 4'd2, 1'b0, "sub2");
    // positive overflow into sign bit
    run_op(1'b0, 16'h7FFF, 16'h0001, 4'd1, 1'b0, "ovf");
    // borrow
    run_op(1'b1, 16'd3, 16'd2, 4'd1, 1'b0, "borrow");
    // zero steps
    run_op(1'b0, 16'hABCD, 16'h1234, 4'd0, 1'b0, "n0");
    // maximum count with wrap
    run_op(1'b0, 16'hFFFF, 16'h0000, 4'd15, 1'b0, "wrap15");
    // negative overflow while subtracting
    run_op(1'b1, 16'h4000, 16'h8100, 4'd3, 1'b0, "subovf");
    // start re-pulsed while busy is ignored
    run_op(1'b1, 16'd5, 16'd20, 4'd3, 1'b1, "repulse");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("repulse no 2nd done", 32'(done), 32'd0);
    end

    // abort mid-operation
    @(negedge clk);
    mode  = 1'b0;
    A     = 16'h0101;
    B     = 16'h0002;
    N     = 4'd10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort Out", 32'(Out), 32'd0);
    check("abort Cout", 32'(Cout), 32'd0);
    check("abort V", 32'(V), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort stays idle", 32'(busy), 32'd0);

    run_op(1'b0, 16'h1111, 16'h0100, 4'd4, 1'b0, "after_abort");
    run_op(1'b1, 16'h0007, 16'hFFF0, 4'd6, 1'b0, "subneg");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
